// File: rtl/obuf_shuffle_pkg.sv
// Shared types and elaboration helpers for the streaming OBUF shuffler.
package obuf_shuffle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic {
        MODE_INTERLEAVE = 1'b0,
        MODE_TRANSPOSE  = 1'b1
    } mode_t;

    // True when a DDR beat splits exactly into `ratio` bank-wide words.
    function automatic bit ratio_ok(input int ddr_bw, input int banks,
                                    input int dw, input int ratio);
        if (banks < 1 || dw < 1 || ratio < 1)
            return 1'b0;
        return ((ddr_bw % (banks * dw)) == 0) && (ratio == ddr_bw / (banks * dw));
    endfunction

endpackage

// File: rtl/obuf_beat_fifo.sv
// Small synchronous FIFO holding whole DDR beats; the head is readable
// combinationally so the shuffler can present word 0 the cycle after a push.
module obuf_beat_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    import obuf_shuffle_pkg::*;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CNT_W'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr_reg];

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= push_data;
    end

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH (not 2^n).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            if (do_pop)
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            if (do_push && !do_pop)
                count_reg <= count_reg + 1'b1;
            else if (do_pop && !do_push)
                count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/obuf_stream_shuffler.sv
// Streaming OBUF shuffler: buffers DDR beats and serialises each into RATIO
// bank-wide words using an interleave or transpose lane mapping.
module obuf_stream_shuffler #(
    parameter int DDR_BANDWIDTH = 512,
    parameter int NUM_BANKS     = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int RATIO         = DDR_BANDWIDTH / (NUM_BANKS * DATA_WIDTH),
    parameter int FIFO_DEPTH    = 2,
    parameter int CNT_W         = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_start,
    input  logic                            cfg_mode,
    input  logic [CNT_W-1:0]                cfg_num_beats,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DDR_BANDWIDTH-1:0]        in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
    output logic                            out_last,
    output logic                            busy,
    output logic                            done
);
    import obuf_shuffle_pkg::*;

    localparam int IDX_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    if (!ratio_ok(DDR_BANDWIDTH, NUM_BANKS, DATA_WIDTH, RATIO)) begin : g_bad_ratio
        $error("obuf_stream_shuffler: DDR_BANDWIDTH must equal RATIO*NUM_BANKS*DATA_WIDTH");
    end
    if (FIFO_DEPTH < 2) begin : g_bad_depth
        $error("obuf_stream_shuffler: FIFO_DEPTH must be at least 2");
    end

    state_t                   state_reg;
    mode_t                    mode_reg;
    logic [CNT_W-1:0]         num_beats_reg;
    logic [CNT_W-1:0]         beats_in_reg;
    logic [CNT_W-1:0]         beats_out_reg;
    logic [IDX_W-1:0]         word_idx_reg;

    logic [DDR_BANDWIDTH-1:0] fifo_head;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [FCNT_W-1:0]        fifo_count;
    logic                     push;
    logic                     pop;
    logic                     out_hs;
    logic                     word_last;

    assign in_ready  = (state_reg == ST_RUN) && !fifo_full && (beats_in_reg < num_beats_reg);
    assign out_valid = (state_reg == ST_RUN) && !fifo_empty;
    assign word_last = (word_idx_reg == IDX_W'(RATIO - 1));
    assign out_last  = out_valid && word_last && (beats_out_reg == num_beats_reg - 1'b1);
    assign push      = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign pop       = out_hs && word_last;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);

    obuf_beat_fifo #(
        .WIDTH (DDR_BANDWIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Each bank lane picks its element from the FIFO head; output is zero when idle.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0] lane_val;

        // Select this lane's element for the current word under the latched mode.
        always_comb begin
            lane_val = '0;
            for (int k = 0; k < RATIO; k++) begin
                if (word_idx_reg == IDX_W'(k)) begin
                    if (mode_reg == MODE_TRANSPOSE)
                        lane_val = fifo_head[(gi * RATIO + k) * DATA_WIDTH +: DATA_WIDTH];
                    else
                        lane_val = fifo_head[(k * NUM_BANKS + gi) * DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end

        assign out_data[gi * DATA_WIDTH +: DATA_WIDTH] = out_valid ? lane_val : '0;
    end

    // Transfer control: configuration latch, FSM and beat/word counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mode_reg      <= MODE_INTERLEAVE;
            num_beats_reg <= '0;
            beats_in_reg  <= '0;
            beats_out_reg <= '0;
            word_idx_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cfg_start) begin
                        mode_reg      <= mode_t'(cfg_mode);
                        num_beats_reg <= cfg_num_beats;
                        beats_in_reg  <= '0;
                        beats_out_reg <= '0;
                        word_idx_reg  <= '0;
                        state_reg     <= (cfg_num_beats == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push)
                        beats_in_reg <= beats_in_reg + 1'b1;
                    if (out_hs) begin
                        if (word_last) begin
                            word_idx_reg  <= '0;
                            beats_out_reg <= beats_out_reg + 1'b1;
                        end else begin
                            word_idx_reg <= word_idx_reg + 1'b1;
                        end
                        if (out_last)
                            state_reg <= ST_DONE;
                    end
                end
                ST_DONE: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/obuf_stream_shuffler.md
# obuf_stream_shuffler

Streaming, parametrised successor to the combinational OBUF shuffler. Sits between the DDR read-data path and the output-buffer (OBUF) bank write port. Accepts full-width DDR beats under valid/ready, buffers them, and serialises each beat into RATIO bank-wide words, one element per bank per word. Supports a run-time-selectable lane mapping (interleave or transpose) and a programmable transfer length with done signalling.

## Interface
- `DDR_BANDWIDTH`, 512: input beat width in bits.
- `NUM_BANKS`, 8: number of OBUF banks; one element per bank per output word.
- `DATA_WIDTH`, 8: element width in bits.
- `RATIO`, `DDR_BANDWIDTH/(NUM_BANKS*DATA_WIDTH)`: output words per beat. Elaboration error if the division is not exact or RATIO < 1.
- `FIFO_DEPTH`, 2: beat buffer entries, minimum 2.
- `CNT_W`, 16: transfer-length counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cfg_start` in 1: one-cycle start pulse, honoured only in IDLE.
- `cfg_mode` in 1: 0 = INTERLEAVE, 1 = TRANSPOSE; latched on start.
- `cfg_num_beats` in CNT_W: number of beats in the transfer; latched on start.
- `in_valid` in 1, `in_ready` out 1, `in_data` in DDR_BANDWIDTH: DDR beat stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out NUM_BANKS*DATA_WIDTH: OBUF word stream. Bank j occupies `out_data[j*DATA_WIDTH +: DATA_WIDTH]`.
- `out_last` out 1: qualifies the final word of the transfer.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at the end of the transfer.

## Operation
- Element e of a beat is `in_data[e*DATA_WIDTH +: DATA_WIDTH]`, for e = 0 .. NUM_BANKS*RATIO-1.
- Output word k (k = 0 .. RATIO-1), lane j:
  - INTERLEAVE: element k*NUM_BANKS + j.
  - TRANSPOSE: element j*RATIO + k.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `cfg_start` with `cfg_num_beats` != 0.
  - IDLE -> DONE on `cfg_start` with `cfg_num_beats` == 0. No data moves in this case.
  - RUN -> DONE on the handshake of the word carrying `out_last`.
  - DONE -> IDLE unconditionally after one cycle. `done` is high only in DONE.
- `cfg_start` is ignored outside IDLE.
- Counters:
  - `beats_in` counts accepted beats.
  - `word_idx` runs 0..RATIO-1 over the FIFO head and wraps to 0 when the head is popped.
  - `beats_out` counts popped beats.
- `in_ready` = RUN && FIFO not full && `beats_in` < num_beats. Beats offered beyond num_beats are never accepted.
- The FIFO head is popped on the handshake of word_idx == RATIO-1. A push and a pop in the same cycle are both legal.
- There is no bypass. The full flag is the registered value, so a full FIFO blocks `in_ready` even in a cycle where a pop occurs.
- `out_last` = `out_valid` && word_idx == RATIO-1 && `beats_out` == num_beats-1.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0, `out_data`=0. FSM goes to IDLE and all counters and FIFO pointers clear.
- Reset asserted mid-transfer aborts immediately. Buffered beats are discarded and no `done` is produced.
- Start to ready: `cfg_start` in cycle t gives `in_ready` high in cycle t+1.
- Latency: a beat accepted in cycle t presents word 0 with `out_valid` in cycle t+1 at the earliest.
- `out_data`, `out_valid` and `out_last` are held stable while `out_valid` && !`out_ready`.
- Throughput: one output word per cycle when `out_ready` is held high. The input then needs one beat every RATIO cycles; at RATIO=1, one beat per cycle with FIFO_DEPTH >= 2.
- The last-word handshake occurs in cycle t. `done` pulses in t+1, and `busy` falls and `in_ready` stays 0 in t+2.

## Structure
- Package `obuf_shuffle_pkg`:
  - state enum (IDLE/RUN/DONE).
  - mode enum (INTERLEAVE=0, TRANSPOSE=1).
  - RATIO-legality check function.
- Sub-module `obuf_beat_fifo`: synchronous FIFO, FIFO_DEPTH x DDR_BANDWIDTH, async active-high reset, with full/empty/count outputs.
- Lane selection is a combinational mux on the FIFO head, indexed by word_idx and the latched mode.

## Test plan
Defaults throughout: 512/8/8, so RATIO=8. Beat b carries element e = (b*64+e) mod 256.
- INTERLEAVE, num_beats=1, `out_ready` high: 8 words. Word k lane j = 8k+j, e.g. word 1 = 8..15. `out_last` is on word 7, and `done` pulses one cycle after it.
- TRANSPOSE, num_beats=1: word 0 lanes = 0,8,16,…,56. Word 7 lanes = 7,15,…,63.
- num_beats=4 with `out_ready` toggled randomly: exactly 32 words, in order, with no duplicates. `out_data` is stable during stalls, and `in_ready` drops while the FIFO holds 2 beats.
- num_beats=2 with a third beat offered: the third beat is never accepted, `busy` falls after `done`, and `in_ready` stays 0.
- `cfg_num_beats`=0: `done` pulses in cycle t+1 with no `out_valid`. A second `cfg_start` pulsed during RUN has no effect.
- `reset` asserted after 3 of 8 words of beat 0: all outputs drop asynchronously to their reset values. A new start then returns the correct word 0.
